rggen_lock_key_sequencer: RTL and testbench

Key-sequence lock controller that produces the lock/enable qualifier consumed by lock-mode and enable-mode bit fields (`i_lock_or_enable`). Software unlocks protected fields by writing two magic keys in order to a key register. The unlock window closes on timeout, on an optional one-shot protected write, on any further key write, or on a force-lock. It sits between the key register's write strobe and every protected bit field in the register block.

---
 rtl/rggen_lock_key_sequencer.sv | 149 ++++++++++++++
 tb/tb_rggen_lock_key_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rggen_lock_key_sequencer.sv
// Key-sequence lock controller: two ordered key writes open a bounded window
// during which lock-mode / enable-mode protected fields may be written.
module rggen_lock_key_sequencer #(
    parameter int                   KEY_WIDTH   = 32,
    parameter logic [KEY_WIDTH-1:0] KEY0        = KEY_WIDTH'(32'h0000_C0DE),
    parameter logic [KEY_WIDTH-1:0] KEY1        = KEY_WIDTH'(32'h0000_5AFE),
    parameter int                   TIMEOUT     = 256,
    parameter int                   ONE_SHOT    = 0,
    parameter int                   COUNT_WIDTH = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_key_valid,
    input  logic [KEY_WIDTH-1:0]   i_key_data,
    input  logic                   i_protected_write,
    input  logic                   i_force_lock,
    output logic                   o_lock,
    output logic                   o_enable,
    output logic                   o_key_error,
    output logic [COUNT_WIDTH-1:0] o_remaining
);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'b00,
        ST_ARMED    = 2'b01,
        ST_UNLOCKED = 2'b10
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_LOAD    = COUNT_WIDTH'(TIMEOUT);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO    = {COUNT_WIDTH{1'b0}};
    localparam logic                   TIMEOUT_EN  = (TIMEOUT != 0);
    localparam logic                   ONE_SHOT_EN = (ONE_SHOT != 0);

    state_t                 state_r;
    logic [COUNT_WIDTH-1:0] cnt_r;
    logic                   lock_r;
    logic                   enable_r;
    logic                   key_error_r;

    logic key0_hit_s;
    logic key1_hit_s;
    logic window_end_s;

    assign key0_hit_s   = (i_key_data == KEY0);
    assign key1_hit_s   = (i_key_data == KEY1);
    // Any key write, a one-shot protected write, or the last counted cycle closes the window.
    assign window_end_s = i_key_valid
                        | (ONE_SHOT_EN & i_protected_write)
                        | (TIMEOUT_EN & (cnt_r == CNT_ONE));

    // Single FSM register: state, window counter and every output move on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_LOCKED;
            cnt_r       <= CNT_ZERO;
            lock_r      <= 1'b1;
            enable_r    <= 1'b0;
            key_error_r <= 1'b0;
        end else if (i_force_lock) begin
            // Force-lock swallows a same-cycle key without flagging it.
            state_r     <= ST_LOCKED;
            cnt_r       <= CNT_ZERO;
            lock_r      <= 1'b1;
            enable_r    <= 1'b0;
            key_error_r <= 1'b0;
        end else begin
            case (state_r)
                ST_LOCKED: begin
                    cnt_r    <= CNT_ZERO;
                    lock_r   <= 1'b1;
                    enable_r <= 1'b0;
                    if (i_key_valid && key0_hit_s) begin
                        state_r     <= ST_ARMED;
                        key_error_r <= 1'b0;
                    end else if (i_key_valid) begin
                        state_r     <= ST_LOCKED;
                        key_error_r <= 1'b1;
                    end else begin
                        state_r     <= ST_LOCKED;
                        key_error_r <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    // KEY1 is checked before KEY0 so equal keys still unlock.
                    if (i_key_valid && key1_hit_s) begin
                        state_r     <= ST_UNLOCKED;
                        cnt_r       <= CNT_LOAD;
                        lock_r      <= 1'b0;
                        enable_r    <= 1'b1;
                        key_error_r <= 1'b0;
                    end else if (i_key_valid && key0_hit_s) begin
                        state_r     <= ST_ARMED;
                        cnt_r       <= CNT_ZERO;
                        lock_r      <= 1'b1;
                        enable_r    <= 1'b0;
                        key_error_r <= 1'b0;
                    end else if (i_key_valid) begin
                        state_r     <= ST_LOCKED;
                        cnt_r       <= CNT_ZERO;
                        lock_r      <= 1'b1;
                        enable_r    <= 1'b0;
                        key_error_r <= 1'b1;
                    end else begin
                        state_r     <= ST_ARMED;
                        cnt_r       <= CNT_ZERO;
                        lock_r      <= 1'b1;
                        enable_r    <= 1'b0;
                        key_error_r <= 1'b0;
                    end
                end
                ST_UNLOCKED: begin
                    key_error_r <= 1'b0;
                    if (window_end_s) begin
                        state_r  <= ST_LOCKED;
                        cnt_r    <= CNT_ZERO;
                        lock_r   <= 1'b1;
                        enable_r <= 1'b0;
                    end else if (TIMEOUT_EN) begin
                        state_r  <= ST_UNLOCKED;
                        cnt_r    <= cnt_r - CNT_ONE;
                        lock_r   <= 1'b0;
                        enable_r <= 1'b1;
                    end else begin
                        // No timeout: window stays open and the counter reads 0.
                        state_r  <= ST_UNLOCKED;
                        cnt_r    <= CNT_ZERO;
                        lock_r   <= 1'b0;
                        enable_r <= 1'b1;
                    end
                end
                default: begin
                    // Corrupted state encoding falls back to the safe locked state.
                    state_r     <= ST_LOCKED;
                    cnt_r       <= CNT_ZERO;
                    lock_r      <= 1'b1;
                    enable_r    <= 1'b0;
                    key_error_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_lock      = lock_r;
    assign o_enable    = enable_r;
    assign o_key_error = key_error_r;
    assign o_remaining = cnt_r;

endmodule

// File: tb/tb_rggen_lock_key_sequencer.sv
// Bench for rggen_lock_key_sequencer: three configurations driven in parallel
// and compared every cycle against a window/arming model.
module tb_rggen_lock_key_sequencer;

    localparam logic [31:0] K0  = 32'h0000_C0DE;
    localparam logic [31:0] K1  = 32'h0000_5AFE;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kv  = 1'b0;
    logic [31:0] kd  = 32'h0;
    logic        pw  = 1'b0;
    logic        fl  = 1'b0;

    logic       lock_a, en_a, err_a;
    logic [2:0] rem_a;
    logic       lock_b, en_b, err_b;
    logic [2:0] rem_b;
    logic       lock_c, en_c, err_c;
    logic [0:0] rem_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rggen_lock_key_sequencer #(.KEY_WIDTH(32), .KEY0(K0), .KEY1(K1), .TIMEOUT(4), .ONE_SHOT(0)) u_a (
        .clk(clk), .rst(rst), .i_key_valid(kv), .i_key_data(kd), .i_protected_write(pw),
        .i_force_lock(fl), .o_lock(lock_a), .o_enable(en_a), .o_key_error(err_a), .o_remaining(rem_a));
    rggen_lock_key_sequencer #(.KEY_WIDTH(32), .KEY0(K0), .KEY1(K1), .TIMEOUT(4), .ONE_SHOT(1)) u_b (
        .clk(clk), .rst(rst), .i_key_valid(kv), .i_key_data(kd), .i_protected_write(pw),
        .i_force_lock(fl), .o_lock(lock_b), .o_enable(en_b), .o_key_error(err_b), .o_remaining(rem_b));
    rggen_lock_key_sequencer #(.KEY_WIDTH(32), .KEY0(K0), .KEY1(K1), .TIMEOUT(0), .ONE_SHOT(0)) u_c (
        .clk(clk), .rst(rst), .i_key_valid(kv), .i_key_data(kd), .i_protected_write(pw),
        .i_force_lock(fl), .o_lock(lock_c), .o_enable(en_c), .o_key_error(err_c), .o_remaining(rem_c));

    // Model view: is the window open, how many cycles remain, is a first key pending.
    typedef struct packed {
        bit open;
        bit armed;
        int left;
        bit err;
    } mst_t;

    mst_t m [3];

    function automatic int tmo_of(int i);
        return (i == 2) ? 0 : 4;
    endfunction

    function automatic bit os_of(int i);
        return (i == 1);
    endfunction

    function automatic mst_t mstep(mst_t s, int tmo, bit os, bit v, logic [31:0] d, bit w, bit f);
        mst_t n;
        n     = s;
        n.err = 1'b0;
        if (f) begin
            n.open = 1'b0; n.armed = 1'b0; n.left = 0;
        end else if (s.open) begin
            if (v || (os && w) || (tmo != 0 && s.left == 1)) begin
                n.open = 1'b0; n.left = 0;
            end else if (tmo != 0) begin
                n.left = s.left - 1;
            end
        end else if (v) begin
            if (s.armed && d == K1) begin
                n.open = 1'b1; n.armed = 1'b0; n.left = tmo;
            end else if (d == K0) begin
                n.armed = 1'b1;
            end else begin
                n.armed = 1'b0; n.err = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) m[i] <= '{1'b0, 1'b0, 0, 1'b0};
        end else begin
            for (int i = 0; i < 3; i++) m[i] <= mstep(m[i], tmo_of(i), os_of(i), kv, kd, pw, fl);
        end
    end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_inst(string nm, int i, logic l, logic e, logic er, int r);
        chk($sformatf("%s.lock", nm), int'(l), m[i].open ? 0 : 1);
        chk($sformatf("%s.enable", nm), int'(e), m[i].open ? 1 : 0);
        chk($sformatf("%s.key_error", nm), int'(er), int'(m[i].err));
        chk($sformatf("%s.remaining", nm), r, m[i].open ? m[i].left : 0);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk_inst("a", 0, lock_a, en_a, err_a, int'(rem_a));
        chk_inst("b", 1, lock_b, en_b, err_b, int'(rem_b));
        chk_inst("c", 2, lock_c, en_c, err_c, int'(rem_c));
    end

    task automatic drv(bit v, logic [31:0] d, bit w, bit f);
        @(negedge clk);
        kv = v; kd = d; pw = w; fl = f;
    endtask

    task automatic idle();
        drv(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset.lock", int'(lock_a), 1);
        chk("reset.enable", int'(en_a), 0);
        chk("reset.key_error", int'(err_a), 0);
        chk("reset.remaining", int'(rem_a), 0);
        rst = 1'b0;

        // Basic unlock window, TIMEOUT=4
        drv(1'b1, K0, 1'b0, 1'b0);
        drv(1'b1, K1, 1'b0, 1'b0);
        idle(); chk("win.rem4", int'(rem_a), 4); chk("win.open", int'(lock_a), 0);
        idle(); chk("win.rem3", int'(rem_a), 3);
        idle(); chk("win.rem2", int'(rem_a), 2);
        idle(); chk("win.rem1", int'(rem_a), 1); chk("win.last_open", int'(lock_a), 0);
        idle(); chk("win.relock", int'(lock_a), 1); chk("win.rem0", int'(rem_a), 0);

        // Wrong second key
        drv(1'b1, K0, 1'b0, 1'b0);
        drv(1'b1, BAD, 1'b0, 1'b0);
        idle(); chk("bad.err", int'(err_a), 1); chk("bad.lock", int'(lock_a), 1);
        drv(1'b1, K1, 1'b0, 1'b0); chk("bad.err_one_cycle", int'(err_a), 0);
        idle(); chk("bad.k1_alone", int'(lock_a), 1);

        // Re-arm and indefinite ARMED hold
        drv(1'b1, K0, 1'b0, 1'b0);
        drv(1'b1, K0, 1'b0, 1'b0);
        repeat (20) idle();
        drv(1'b1, K1, 1'b0, 1'b0);
        idle(); chk("rearm.open", int'(lock_a), 0);
        repeat (6) idle(); chk("rearm.timeout", int'(lock_a), 1);

        // One-shot relock on instance b
        drv(1'b1, K0, 1'b0, 1'b0);
        drv(1'b1, K1, 1'b0, 1'b0);
        idle(); chk("os.open", int'(lock_b), 0); chk("os.rem4", int'(rem_b), 4);
        drv(1'b0, 32'h0, 1'b1, 1'b0); chk("os.write_accepted", int'(lock_b), 0);
        idle(); chk("os.relock", int'(lock_b), 1); chk("os.rem0", int'(rem_b), 0);
        chk("os.other_open", int'(lock_a), 0); chk("os.other_rem2", int'(rem_a), 2);
        repeat (4) idle();

        // Force-lock with simultaneous KEY0
        drv(1'b1, K0, 1'b0, 1'b0);
        drv(1'b1, K1, 1'b0, 1'b0);
        idle(); chk("fl.open", int'(lock_a), 0);
        drv(1'b1, K0, 1'b0, 1'b1);
        idle(); chk("fl.lock", int'(lock_a), 1); chk("fl.no_err", int'(err_a), 0);
        drv(1'b1, K1, 1'b0, 1'b0);
        idle(); chk("fl.not_armed", int'(lock_a), 1); chk("fl.k1_rejected", int'(err_a), 1);

        // Asynchronous reset mid-window
        drv(1'b1, K0, 1'b0, 1'b0);
        drv(1'b1, K1, 1'b0, 1'b0);
        idle(); chk("rst.open", int'(lock_a), 0);
        #2 rst = 1'b1;
        #1 chk("rst.async_lock", int'(lock_a), 1); chk("rst.rem0", int'(rem_a), 0);
        @(negedge clk); rst = 1'b0;

        // No-timeout configuration on instance c
        drv(1'b1, K0, 1'b0, 1'b0);
        drv(1'b1, K1, 1'b0, 1'b0);
        repeat (1000) idle();
        chk("nt.open", int'(lock_c), 0); chk("nt.rem0", int'(rem_c), 0); chk("nt.enable", int'(en_c), 1);
        drv(1'b1, K0, 1'b0, 1'b0);
        idle(); chk("nt.relock", int'(lock_c), 1); chk("nt.no_err", int'(err_c), 0);
        repeat (3) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
